// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : divider_arbiter
// Description : Round-robin arbiter sharing one divider core among N_REQ
//               requesters. Each grant issues one division and returns the
//               result to the granted requester.
//               Optional WAIT timeout enabled with macro DIV_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DATA_W-1:0]   values_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          done_o,
    output logic [DATA_W-1:0]         result_o,
    output logic                      err_o,
    output logic                      div_req_o,
    output logic [DATA_W-1:0]         div_values_o,
    input  logic                      div_ack_i,
    input  logic [DATA_W-1:0]         div_result_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0] c_n_req = (PTR_W+1)'(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       w_rr_ptr_nxt;
    logic                   w_found;
    logic [PTR_W-1:0]       w_pick;
    logic [PTR_W:0]         w_idx;
    logic [PTR_W:0]         w_ptr_inc;
    logic [N_REQ-1:0]       w_gnt_nxt;
    logic [N_REQ-1:0]       w_done_nxt;
    logic [DATA_W-1:0]      w_result_nxt;
    logic [DATA_W-1:0]      w_values_nxt;
    logic                   w_div_req_nxt;
    logic                   w_timeout;
    logic [DATA_W-1:0]      w_vals [N_REQ];

    // Unpack the flat operand bus into one word per requester
    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_vals[g] = values_i[g*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin pick: scan offsets high to low so the nearest request at or
    // above the pointer is the one left standing
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
            if (w_idx >= c_n_req) begin
                w_idx = w_idx - c_n_req;
            end
            if (req_i[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[PTR_W-1:0];
            end
        end
        w_ptr_inc = {1'b0, w_pick} + (PTR_W+1)'(1);
    end

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_err_nxt;

    // Count WAIT cycles; restarts at zero on every entry to WAIT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == c_to_last);

    // Error flag accompanies done_o for an aborted operation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_o <= 1'b0;
        end else begin
            err_o <= w_err_nxt;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_gnt_nxt     = gnt_o;
        w_done_nxt    = '0;
        w_div_req_nxt = 1'b0;
        w_result_nxt  = result_o;
        w_values_nxt  = div_values_o;
`ifdef DIV_ARB_TIMEOUT_EN
        w_err_nxt     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = S_ISSUE;
                    w_gnt_nxt     = N_REQ'(1) << w_pick;
                    w_values_nxt  = w_vals[w_pick];
                    w_div_req_nxt = 1'b1;
                    w_rr_ptr_nxt  = (w_ptr_inc >= c_n_req) ? '0 : w_ptr_inc[PTR_W-1:0];
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (div_ack_i) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = div_result_i;
                    w_done_nxt   = gnt_o;
                end else if (w_timeout) begin
                    w_state_nxt  = S_DONE;
                    w_result_nxt = '0;
                    w_done_nxt   = gnt_o;
`ifdef DIV_ARB_TIMEOUT_EN
                    w_err_nxt    = 1'b1;
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State and round-robin pointer register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Registered outputs, so every pulse is glitch-free and one cycle wide
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_o        <= '0;
            done_o       <= '0;
            result_o     <= '0;
            div_req_o    <= 1'b0;
            div_values_o <= '0;
        end else begin
            gnt_o        <= w_gnt_nxt;
            done_o       <= w_done_nxt;
            result_o     <= w_result_nxt;
            div_req_o    <= w_div_req_nxt;
            div_values_o <= w_values_nxt;
        end
    end

endmodule
`default_nettype wire
